// File: rtl/apb_cmd_master_pkg.sv
// Shared types and defaults for the APB command master: state encoding,
// response-code bit positions and default widths.
package apb_cmd_master_pkg;

  localparam int DEF_ADDRESS_SIZE   = 32;
  localparam int DEF_REG_WIDTH      = 8;
  localparam int DEF_TIMEOUT_CYCLES = 16;

  typedef logic [1:0] state_t;

  localparam state_t ST_IDLE   = 2'd0;
  localparam state_t ST_SETUP  = 2'd1;
  localparam state_t ST_ACCESS = 2'd2;
  localparam state_t ST_RESP   = 2'd3;

  localparam int RSP_ERR_BIT     = 0;
  localparam int RSP_TIMEOUT_BIT = 1;
  localparam int RSP_CODE_W      = 2;

  typedef logic [RSP_CODE_W-1:0] rsp_code_t;

endpackage

// File: rtl/apb_cmd_master_if.sv
// Command/response handshake plus APB requester bus, bundled for the
// command master (master modport) and whatever drives/observes it (slave).
interface apb_cmd_master_if import apb_cmd_master_pkg::*; #(
  parameter int ADDRESS_SIZE = DEF_ADDRESS_SIZE,
  parameter int REG_WIDTH    = DEF_REG_WIDTH
) ();

  logic                    cmd_valid;
  logic                    cmd_ready;
  logic                    cmd_write;
  logic [ADDRESS_SIZE-1:0] cmd_addr;
  logic [REG_WIDTH-1:0]    cmd_wdata;

  logic                    rsp_valid;
  logic                    rsp_ready;
  logic [REG_WIDTH-1:0]    rsp_rdata;
  logic                    rsp_err;
  logic                    rsp_timeout;

  logic [ADDRESS_SIZE-1:0] addr;
  logic                    sel;
  logic                    en;
  logic                    write;
  logic [REG_WIDTH-1:0]    wdata;
  logic [REG_WIDTH-1:0]    rdata;
  logic                    ready;
  logic                    slv_err;

  modport master (
    input  cmd_valid, cmd_write, cmd_addr, cmd_wdata, rsp_ready,
    input  rdata, ready, slv_err,
    output cmd_ready, rsp_valid, rsp_rdata, rsp_err, rsp_timeout,
    output addr, sel, en, write, wdata
  );

  modport slave (
    output cmd_valid, cmd_write, cmd_addr, cmd_wdata, rsp_ready,
    output rdata, ready, slv_err,
    input  cmd_ready, rsp_valid, rsp_rdata, rsp_err, rsp_timeout,
    input  addr, sel, en, write, wdata
  );

endinterface

// File: rtl/apb_cmd_master_access_watchdog.sv
// ACCESS-phase watchdog: counts wait-state cycles and flags expiry on the
// last allowed cycle; only instantiated when APB_CMD_MASTER_TIMEOUT_EN is set.
module apb_access_watchdog import apb_cmd_master_pkg::*; #(
  parameter int TIMEOUT_CYCLES = DEF_TIMEOUT_CYCLES
) (
  input  logic clk,
  input  logic rst,
  input  logic i_clear,
  input  logic i_active,
  input  logic i_ready,
  output logic o_expired
);

  localparam int CNT_W = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

  logic [CNT_W-1:0] r_count;

  // ready in the expiry cycle takes priority, so expiry requires ready low
  assign o_expired = i_active && !i_ready && (r_count == CNT_LAST);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_count <= '0;
    end else if (i_clear) begin
      r_count <= '0;
    end else if (i_active && !i_ready && !o_expired) begin
      r_count <= r_count + 1'b1;
    end
  end

endmodule

// File: rtl/apb_cmd_master.sv
// APB requester: turns valid/ready commands into SETUP/ACCESS transfers and
// returns one response each. Optional ACCESS watchdog: APB_CMD_MASTER_TIMEOUT_EN.
module apb_cmd_master import apb_cmd_master_pkg::*; #(
  parameter int ADDRESS_SIZE   = DEF_ADDRESS_SIZE,
  parameter int REG_WIDTH      = DEF_REG_WIDTH,
  parameter int TIMEOUT_CYCLES = DEF_TIMEOUT_CYCLES
) (
  input  logic             clk,
  input  logic             rst,
  apb_cmd_master_if.master bus
);

  state_t                  r_state;
  logic                    r_write;
  logic [ADDRESS_SIZE-1:0] r_addr;
  logic [REG_WIDTH-1:0]    r_wdata;
  logic [REG_WIDTH-1:0]    r_rsp_rdata;
  rsp_code_t               r_rsp_code;

  logic w_sel;
  logic w_timeout;

`ifdef APB_CMD_MASTER_TIMEOUT_EN
  apb_access_watchdog #(
    .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
  ) u_watchdog (
    .clk       (clk),
    .rst       (rst),
    .i_clear   (r_state == ST_SETUP),
    .i_active  (r_state == ST_ACCESS),
    .i_ready   (bus.ready),
    .o_expired (w_timeout)
  );
`else
  logic w_unused_timeout_cfg;
  assign w_unused_timeout_cfg = (TIMEOUT_CYCLES > 0);
  assign w_timeout = 1'b0;
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state     <= ST_IDLE;
      r_write     <= 1'b0;
      r_addr      <= '0;
      r_wdata     <= '0;
      r_rsp_rdata <= '0;
      r_rsp_code  <= '0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (bus.cmd_valid) begin
            r_write <= bus.cmd_write;
            r_addr  <= bus.cmd_addr;
            r_wdata <= bus.cmd_wdata;
            r_state <= ST_SETUP;
          end
        end
        ST_SETUP: begin
          r_state <= ST_ACCESS;
        end
        ST_ACCESS: begin
          if (bus.ready) begin
            r_rsp_rdata                  <= r_write ? '0 : bus.rdata;
            r_rsp_code[RSP_ERR_BIT]      <= bus.slv_err;
            r_rsp_code[RSP_TIMEOUT_BIT]  <= 1'b0;
            r_state                      <= ST_RESP;
          end else if (w_timeout) begin
            r_rsp_rdata                  <= '0;
            r_rsp_code[RSP_ERR_BIT]      <= 1'b1;
            r_rsp_code[RSP_TIMEOUT_BIT]  <= 1'b1;
            r_state                      <= ST_RESP;
          end
        end
        ST_RESP: begin
          if (bus.rsp_ready) begin
            r_state <= ST_IDLE;
          end
        end
        default: begin
          r_state <= ST_IDLE;
        end
      endcase
    end
  end

  assign w_sel = (r_state == ST_SETUP) || (r_state == ST_ACCESS);

  // outputs decode straight from state so reset drops sel/en immediately
  assign bus.sel   = w_sel;
  assign bus.en    = (r_state == ST_ACCESS);
  assign bus.addr  = w_sel ? r_addr : '0;
  assign bus.write = w_sel && r_write;
  assign bus.wdata = (w_sel && r_write) ? r_wdata : '0;

  assign bus.cmd_ready   = (r_state == ST_IDLE) && !rst;
  assign bus.rsp_valid   = (r_state == ST_RESP);
  assign bus.rsp_rdata   = r_rsp_rdata;
  assign bus.rsp_err     = r_rsp_code[RSP_ERR_BIT];
  assign bus.rsp_timeout = r_rsp_code[RSP_TIMEOUT_BIT];

endmodule

// File: doc/apb_cmd_master.md
# apb_cmd_master

APB requester that sits directly upstream of the CSR block and drives its `addr`/`sel`/`en`/`write`/`wdata` bus from a simple valid/ready command interface. It sequences each command through the APB SETUP and ACCESS phases, honours `ready` wait states, captures `rdata` and `slv_err`, and returns one response per command. It allows a processor-side or test sequencer to reach the register bank without hand-driving APB phases.

## Interface
- `ADDRESS_SIZE`, 32, APB address width
- `REG_WIDTH`, 8, data width, matching the CSR register width
- `TIMEOUT_CYCLES`, 16, maximum ACCESS-phase cycles before abort; used only when `APB_CMD_MASTER_TIMEOUT_EN` is defined
- `clk` input 1: single clock, all state on the rising edge
- `rst` input 1: asynchronous, active-high reset
- `cmd_valid` input 1: command present
- `cmd_ready` output 1: command accepted when high together with `cmd_valid`
- `cmd_write` input 1: 1 = write, 0 = read
- `cmd_addr` input ADDRESS_SIZE: target address
- `cmd_wdata` input REG_WIDTH: write data
- `rsp_valid` output 1: response present
- `rsp_ready` input 1: response consumed when high together with `rsp_valid`
- `rsp_rdata` output REG_WIDTH: read data; 0 for writes
- `rsp_err` output 1: slave error, or timeout
- `rsp_timeout` output 1: access aborted by watchdog; constant 0 without the macro
- `addr` output ADDRESS_SIZE: APB address
- `sel` output 1: APB select
- `en` output 1: APB enable
- `write` output 1: APB direction
- `wdata` output REG_WIDTH: APB write data
- `rdata` input REG_WIDTH: APB read data
- `ready` input 1: APB ready
- `slv_err` input 1: APB slave error, sampled with `ready`

## Operation
- The FSM has four states: IDLE, SETUP, ACCESS and RESP. The encoding is IDLE=0, SETUP=1, ACCESS=2, RESP=3.
- **IDLE:**
  - `cmd_ready`=1.
  - On `cmd_valid`, capture `cmd_write`, `cmd_addr` and `cmd_wdata` into registers, then move to SETUP.
- **SETUP:** `sel`=1, `en`=0, with `addr`, `write` and `wdata` driven from the captured registers. Always moves to ACCESS after one cycle.
- **ACCESS:**
  - `sel`=1, `en`=1, and all address, direction and data outputs held unchanged.
  - On `ready`=1, capture `rdata` (reads only; writes capture 0) and `slv_err` into the response registers, then move to RESP.
  - On `ready`=0, remain in ACCESS.
- **RESP:**
  - `sel`=0, `en`=0, `rsp_valid`=1, and the response fields held stable.
  - On `rsp_ready`, move to IDLE.
- `cmd_ready` is high only in IDLE, so at most one command is in flight and there is no command buffering.
- `wdata` is driven with the captured write data during write transfers only; it is 0 for reads and while idle.
- `addr` and `write` are 0 whenever `sel`=0.
- `slv_err` is ignored unless `ready`=1 in ACCESS.

## Timing
- Every output resets to 0, and the FSM resets to IDLE.
- Reset takes effect asynchronously: an in-flight transfer is dropped, no response is produced, and `sel`/`en` fall in the same cycle.
- Minimum latency, with the command accepted at edge 0 and a zero-wait slave:
  - SETUP runs in cycle 1.
  - ACCESS runs in cycle 2, with `ready` sampled at edge 3.
  - `rsp_valid` is high from cycle 3.
- Each cycle `ready` stays low in ACCESS adds one cycle to this latency.
- Back-to-back throughput: when `rsp_ready` is high in the first RESP cycle, `cmd_ready` is high in the next cycle, giving 4 cycles per command minimum.
- If `rsp_ready` is held low, RESP holds indefinitely and new commands stall.

## Configuration
- `APB_CMD_MASTER_TIMEOUT_EN` defined:
  - A counter clears on entry to ACCESS and increments each ACCESS cycle with `ready`=0.
  - When it reaches TIMEOUT_CYCLES−1 with `ready` still low, the FSM goes to RESP with `rsp_err`=1, `rsp_timeout`=1 and `rsp_rdata`=0, and `sel`/`en` drop.
  - If `ready` and the timeout condition occur in the same cycle, `ready` wins and the response is normal.
- `APB_CMD_MASTER_TIMEOUT_EN` undefined: there is no counter, ACCESS waits for `ready` indefinitely, and `rsp_timeout` is tied to 0.

## Structure
- Package `apb_cmd_master_pkg` holds:
  - the state typedef and its encoding;
  - the response-code bit positions;
  - the default widths.
- Sub-module `apb_access_watchdog` contains the timeout counter and its compare. It is instantiated only under the macro.

## Test plan
- **Zero-wait write:**
  - Stimulus: `cmd_write`=1, `cmd_addr`=0x04, `cmd_wdata`=0x5A, with `ready` tied high.
  - Required response: SETUP and ACCESS appear on consecutive cycles with `addr`=0x04 and `wdata`=0x5A; `rsp_valid` is high 3 cycles after acceptance with `rsp_err`=0 and `rsp_rdata`=0.
- **Wait-state read:**
  - Stimulus: read from 0x08 with `ready` low for 3 ACCESS cycles and `rdata`=0xAF when `ready` rises.
  - Required response: `en` is high for 4 cycles, `rsp_rdata`=0xAF, latency is 6.
- **Slave error:**
  - Stimulus: `slv_err`=1 with `ready`.
  - Required response: `rsp_err`=1 and `rsp_timeout`=0. A second command with `slv_err`=0 returns `rsp_err`=0.
- **Response backpressure:**
  - Stimulus: hold `rsp_ready`=0 for 5 cycles.
  - Required response: RESP holds, `cmd_ready`=0 throughout, and `sel`=0.
- **Reset mid-ACCESS:**
  - Stimulus: assert `rst` while `en`=1.
  - Required response: `sel`, `en` and `rsp_valid` drop immediately, and the next command after reset completes normally.
- **Timeout (macro defined, TIMEOUT_CYCLES=16):**
  - Stimulus: `ready` held low.
  - Required response: after 16 ACCESS cycles `rsp_err`=1, `rsp_timeout`=1, `sel`=0.
